// File: rtl/sensor_ctrl_burst.sv
// Sensor burst controller: requests 8-lane bursts into a DEPTH-word buffer and raises an interrupt when the buffer is full.
// Define SCTRL_OVF_CNT_EN to add the sctrl_ovf_cnt port, which counts bursts that arrive while the buffer is full.
module sensor_ctrl_burst #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          sctrl_en,
    input  logic          sctrl_clear,
    input  logic          sensor_ready,
    input  logic [31:0]   sensor_out_0,
    input  logic [31:0]   sensor_out_1,
    input  logic [31:0]   sensor_out_2,
    input  logic [31:0]   sensor_out_3,
    input  logic [31:0]   sensor_out_4,
    input  logic [31:0]   sensor_out_5,
    input  logic [31:0]   sensor_out_6,
    input  logic [31:0]   sensor_out_7,
    output logic          sensor_en,
    input  logic [AW-1:0] sctrl_addr,
    output logic [31:0]   sctrl_out,
    output logic          sctrl_interrupt
`ifdef SCTRL_OVF_CNT_EN
    ,
    output logic [7:0]    sctrl_ovf_cnt
`endif
);

    // state | meaning
    // IDLE  | no request to the sensor; waits for sctrl_en
    // REQ   | sensor_en high; every sensor_ready captures one 8-word burst
    // FULL  | buffer full; interrupt held until sctrl_clear
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] wr_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] wr_ptr_inc;
    logic        wr_en;
    logic [31:0] buf_mem [DEPTH];
    logic [31:0] lane [8];

    assign lane[0] = sensor_out_0;
    assign lane[1] = sensor_out_1;
    assign lane[2] = sensor_out_2;
    assign lane[3] = sensor_out_3;
    assign lane[4] = sensor_out_4;
    assign lane[5] = sensor_out_5;
    assign lane[6] = sensor_out_6;
    assign lane[7] = sensor_out_7;

    assign wr_ptr_inc = wr_ptr + (AW+1)'(8);

    // Dropping sctrl_en in REQ wins over a coincident burst: nothing is captured.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_en      = 1'b0;
        if (sctrl_clear) begin
            state_nxt  = IDLE;
            wr_ptr_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sctrl_en) state_nxt = REQ;
                end
                REQ: begin
                    if (!sctrl_en) begin
                        state_nxt = IDLE;
                    end else if (sensor_ready) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr_inc;
                        if (wr_ptr_inc == (AW+1)'(DEPTH)) state_nxt = FULL;
                    end
                end
                FULL: begin
                    state_nxt = FULL;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            sensor_en       <= 1'b0;
            sctrl_interrupt <= 1'b0;
        end else begin
            state           <= state_nxt;
            wr_ptr          <= wr_ptr_nxt;
            sensor_en       <= (state_nxt == REQ);
            sctrl_interrupt <= (state_nxt == FULL);
        end
    end

    // wr_ptr is always a multiple of 8, so OR-ing in the lane index forms the address.
    always_ff @(posedge cpu_clk) begin
        if (wr_en && !cpu_rst) begin
            for (int k = 0; k < 8; k++) begin
                buf_mem[wr_ptr[AW-1:0] | AW'(k)] <= lane[k];
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sctrl_out <= '0;
        end else begin
            sctrl_out <= buf_mem[sctrl_addr];
        end
    end

`ifdef SCTRL_OVF_CNT_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || sctrl_clear) begin
            sctrl_ovf_cnt <= '0;
        end else if (state == FULL && sensor_ready && sctrl_ovf_cnt != 8'hFF) begin
            sctrl_ovf_cnt <= sctrl_ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/sensor_ctrl_burst.md
Name: sensor_ctrl_burst

Overview:
- Sensor controller in the cpu_clk domain, directly downstream of the external 8-lane sensor interface (sensor_en / sensor_ready / sensor_out_0..7).
- Requests sensor bursts and captures each 8-word burst in one cycle into an internal buffer of DEPTH 32-bit words.
- Raises an interrupt when the buffer is full.
- The CPU-side bus wrapper reads the buffer through a registered read port and clears it to start the next acquisition.

Parameters:
- DEPTH, 64, buffer size in 32-bit words; multiple of 8, power of two, ≥ 8.
- AW, $clog2(DEPTH), buffer address width.

Ports:
- cpu_clk  in  1  block clock; all logic on rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- sctrl_en  in  1  acquisition enable (level, from control register).
- sctrl_clear  in  1  single-cycle pulse; empties buffer, drops interrupt.
- sensor_ready  in  1  burst valid; qualifies sensor_out_0..7 for this cycle.
- sensor_out_0 .. sensor_out_7  in  32 each  burst words; lane k is stored at wr_ptr+k.
- sensor_en  out  1  request to sensor; registered.
- sctrl_addr  in  AW  buffer read address.
- sctrl_out  out  32  buffer read data; 1-cycle latency.
- sctrl_interrupt  out  1  buffer full; level; registered.
- sctrl_ovf_cnt  out  8  overflow count; present only with SCTRL_OVF_CNT_EN.

Behaviour:
- Reset (cpu_rst=1 at a rising edge):
  - state=IDLE, wr_ptr=0, sensor_en=0, sctrl_interrupt=0, sctrl_out=0.
  - Buffer contents are not cleared.
  - Reset mid-burst aborts; nothing is written that cycle.
- States:
  - IDLE: sensor_en=0. Go to REQ when sctrl_en=1 and sctrl_clear=0.
  - REQ: sensor_en=1.
    - sctrl_en=0 → IDLE; wr_ptr is kept, so acquisition resumes where it stopped.
    - sensor_ready=1 → write sensor_out_k to buf[wr_ptr+k] for k=0..7; wr_ptr += 8.
    - If the new wr_ptr equals DEPTH (wraps to 0 in AW bits) → FULL; otherwise stay in REQ.
  - FULL: sensor_en=0, sctrl_interrupt=1. Ignore sensor_ready and sctrl_en. Leave only on sctrl_clear.
- Timing:
  - sensor_en is registered: deasserts the cycle after the last burst is captured.
  - sctrl_interrupt asserts that same cycle.
- sctrl_clear, any state, highest priority after reset:
  - wr_ptr=0, sctrl_interrupt=0, state=IDLE.
  - A sensor_ready in the same cycle is dropped; nothing is written.
  - Next cycle → REQ if sctrl_en=1.
- sensor_ready outside REQ (IDLE or FULL): ignored, no write.
- sensor_en=1 with sensor_ready=0: hold the request indefinitely; no timeout.
- wr_ptr:
  - AW+1 bits internally so full (DEPTH) and empty (0) are distinct.
  - Only multiples of 8 occur.
- Read port:
  - sctrl_out <= buf[sctrl_addr] every cycle, independent of state.
  - Read and write of the same address in the same cycle returns the old data (read-before-write).
- sensor_out_* values are X when sensor_ready=0 and must never reach the buffer.

Optional Feature:
- Macro: SCTRL_OVF_CNT_EN.
- Defined:
  - sctrl_ovf_cnt (8b) counts cycles with sensor_ready=1 while state=FULL.
  - Saturates at 8'hFF.
  - Reset to 0 on cpu_rst or sctrl_clear.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then sctrl_en=1, DEPTH=64, 8 bursts with lane k of burst b = 32'hB000_0000|(b<<4)|k:
  - sensor_en=1 one cycle after enable.
  - After the 8th burst: sctrl_interrupt=1, sensor_en=0.
  - Reading addr 0x0D then returns 32'hB000_0015 one cycle later.
- Drop sctrl_en after 3 bursts, wait 20 cycles, re-enable, send 5 bursts:
  - wr_ptr resumes at 24.
  - Interrupt only after the 5th burst.
  - addr 24 holds the first word of the 4th burst.
- In FULL, pulse sensor_ready 300 times:
  - buffer unchanged, sensor_en stays 0.
  - With SCTRL_OVF_CNT_EN: sctrl_ovf_cnt=8'hFF.
- sctrl_clear coincident with sensor_ready in REQ after 2 bursts:
  - no write; wr_ptr=0; interrupt=0.
  - Next burst lands at addr 0..7.
- Assert cpu_rst during REQ with sensor_ready=1:
  - next cycle sensor_en=0, sctrl_interrupt=0, sctrl_out=0.
  - Re-enable; the first burst lands at addr 0.
- Read addr 8 in the same cycle burst 2 writes addr 8..15:
  - sctrl_out shows the pre-write value.
  - A read one cycle later shows the new lane-0 word.
